// File: rtl/kbd_ring_pkg.sv
// -----------------------------------------------------------------------------
// kbd_ring_pkg
//
// Shared definitions for the keyboard ring writer:
//   - kbd_state_e : FSM state encoding of kbd_ring_writer
//   - TAIL_OFS / HEAD_OFS / DATA_OFS : byte offsets inside the ring control
//     block (tail word, head word, first data word)
//   - KBD_RING_* : default CPU-side memory map, kept here so the software
//     header and the RTL are generated from the same numbers
//   - clog2() : ring pointer width for a given ring depth
// -----------------------------------------------------------------------------
package kbd_ring_pkg;

    typedef enum logic [2:0] {
        ST_INIT_TAIL = 3'd0,
        ST_INIT_HEAD = 3'd1,
        ST_IDLE      = 3'd2,
        ST_RD_HEAD   = 3'd3,
        ST_WAIT_HEAD = 3'd4,
        ST_WR_DATA   = 3'd5,
        ST_WR_TAIL   = 3'd6
    } kbd_state_e;

    localparam logic [31:0] TAIL_OFS = 32'd0;
    localparam logic [31:0] HEAD_OFS = 32'd4;
    localparam logic [31:0] DATA_OFS = 32'd8;

    // CPU-visible memory map of the default build.
    localparam logic [31:0] KBD_RING_BASE_ADDR = 32'h0000_1000;
    localparam int          KBD_RING_DEPTH     = 16;
    localparam logic [31:0] KBD_RING_TAIL_ADDR = KBD_RING_BASE_ADDR + TAIL_OFS;
    localparam logic [31:0] KBD_RING_HEAD_ADDR = KBD_RING_BASE_ADDR + HEAD_OFS;
    localparam logic [31:0] KBD_RING_DATA_ADDR = KBD_RING_BASE_ADDR + DATA_OFS;

    // Ceiling log2; gives the ring pointer width for a power-of-2 depth.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : kbd_ring_pkg

// File: rtl/kbd_ring_writer.sv
// -----------------------------------------------------------------------------
// kbd_ring_writer
//
// Pushes PS/2 scancodes into a word ring buffer held in data memory, using
// memory port B as a bus master. The bridge owns the tail word, the CPU owns
// the head word; both live in the control block at BASE_ADDR.
//
// Ports:
//   clk        in   memory port B clock
//   rst        in   synchronous, active-high reset
//   kbd_code   in   [7:0]  scancode from the PS/2 receiver
//   kbd_valid  in          kbd_code valid
//   kbd_ready  out         code accepted this cycle when kbd_valid is high
//   io_addr    out  [31:0] port B byte address (word aligned)
//   io_wren    out         port B write enable
//   io_wdata   out  [31:0] port B write data
//   io_rdata   in   [31:0] port B read data, RD_LAT cycles after io_addr
//   busy       out         high in every state except IDLE
//   ovf_cnt    out  [15:0] saturating count of dropped codes
//                          (present only when KBD_RING_DROP_EN is defined)
//
// Build option KBD_RING_DROP_EN: when the ring is full the pending code is
// dropped and counted instead of stalling the keyboard side.
// -----------------------------------------------------------------------------
module kbd_ring_writer
    import kbd_ring_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          DEPTH     = 16,
    parameter int          RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  kbd_code,
    input  logic        kbd_valid,
    output logic        kbd_ready,
    output logic [31:0] io_addr,
    output logic        io_wren,
    output logic [31:0] io_wdata,
    input  logic [31:0] io_rdata,
`ifdef KBD_RING_DROP_EN
    output logic [15:0] ovf_cnt,
`endif
    output logic        busy
);

    localparam int PW = clog2(DEPTH);

    kbd_state_e      state_q, state_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [7:0]      code_q, code_d;
    logic [1:0]      cnt_q, cnt_d;
    // Low during reset and for the first cycle after it, so the INIT_TAIL
    // write is only driven once the memory is out of reset.
    logic            run_q;
    logic [PW-1:0]   next_tail;
    logic [PW-1:0]   head;
`ifdef KBD_RING_DROP_EN
    logic [15:0]     ovf_q, ovf_d;
`endif

    // Only the pointer bits of the head word matter.
    logic unused_rdata;
    assign unused_rdata = ^io_rdata[31:PW];

    assign next_tail = tail_q + PW'(1);
    assign head      = io_rdata[PW-1:0];

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        tail_d  = tail_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
`ifdef KBD_RING_DROP_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_INIT_TAIL: begin
                if (run_q) begin
                    state_d = ST_INIT_HEAD;
                end
            end
            ST_INIT_HEAD: state_d = ST_IDLE;
            ST_IDLE: begin
                if (kbd_valid) begin
                    code_d  = kbd_code;
                    state_d = ST_RD_HEAD;
                end
            end
            ST_RD_HEAD: begin
                cnt_d   = 2'(RD_LAT);
                state_d = ST_WAIT_HEAD;
            end
            ST_WAIT_HEAD: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    // One slot stays empty: advancing onto head means full.
                    if (next_tail == head) begin
`ifdef KBD_RING_DROP_EN
                        state_d = ST_IDLE;
                        if (ovf_q != 16'hFFFF) begin
                            ovf_d = ovf_q + 16'd1;
                        end
`else
                        state_d = ST_RD_HEAD;
`endif
                    end else begin
                        state_d = ST_WR_DATA;
                    end
                end
            end
            ST_WR_DATA: state_d = ST_WR_TAIL;
            ST_WR_TAIL: begin
                tail_d  = next_tail;
                state_d = ST_IDLE;
            end
            default: state_d = ST_INIT_TAIL;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    // Decoded from registered state only; kbd_valid and io_rdata never reach
    // an output combinationally.
    always_comb begin
        io_addr  = BASE_ADDR + TAIL_OFS;
        io_wren  = 1'b0;
        io_wdata = 32'd0;
        case (state_q)
            ST_INIT_TAIL: io_wren = run_q;
            ST_INIT_HEAD: begin
                io_addr = BASE_ADDR + HEAD_OFS;
                io_wren = 1'b1;
            end
            ST_RD_HEAD, ST_WAIT_HEAD: io_addr = BASE_ADDR + HEAD_OFS;
            ST_WR_DATA: begin
                io_addr  = BASE_ADDR + DATA_OFS + {{(30-PW){1'b0}}, tail_q, 2'b00};
                io_wdata = {24'd0, code_q};
                io_wren  = 1'b1;
            end
            ST_WR_TAIL: begin
                // Tail moves only after its data word is in memory.
                io_wdata = {{(32-PW){1'b0}}, next_tail};
                io_wren  = 1'b1;
            end
            default: ;
        endcase
    end

    assign kbd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
`ifdef KBD_RING_DROP_EN
    assign ovf_cnt   = ovf_q;
`endif

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT_TAIL;
            tail_q  <= '0;
            cnt_q   <= 2'd0;
            run_q   <= 1'b0;
`ifdef KBD_RING_DROP_EN
            ovf_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
`ifdef KBD_RING_DROP_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        code_q <= code_d;
    end

endmodule : kbd_ring_writer

// File: tb/tb_kbd_ring_writer.sv
// -----------------------------------------------------------------------------
// tb_kbd_ring_writer
//
// Bench for kbd_ring_writer with a port-B memory model of latency RD_LAT and a
// CPU-side consumer that moves the head word. A ring model (tail, queue of
// stored codes, pending codes) predicts the exact sequence of port-B writes;
// every write the DUT issues is compared against that sequence.
// -----------------------------------------------------------------------------
module tb_kbd_ring_writer;

    localparam int          RD_LAT = 1;
    localparam int          DEPTH  = 16;
    localparam logic [31:0] BASE   = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic [7:0]  kbd_code;
    logic        kbd_valid;
    logic        kbd_ready;
    logic [31:0] io_addr;
    logic        io_wren;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        busy;
`ifdef KBD_RING_DROP_EN
    logic [15:0] ovf_cnt;
`endif

    kbd_ring_writer #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .kbd_code  (kbd_code),
        .kbd_valid (kbd_valid),
        .kbd_ready (kbd_ready),
        .io_addr   (io_addr),
        .io_wren   (io_wren),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
`ifdef KBD_RING_DROP_EN
        .ovf_cnt   (ovf_cnt),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // ---------------- port-B memory and CPU write port
    function automatic logic [9:0] widx(input logic [31:0] a);
        return a[11:2];
    endfunction

    bit [31:0]   mem     [0:1023];
    bit [31:0]   rd_pipe [0:RD_LAT-1];
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;

    always @(posedge clk) begin
        for (int k = RD_LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
        rd_pipe[0] <= mem[widx(io_addr)];
        if (io_wren) mem[widx(io_addr)] <= io_wdata;
        if (cpu_we)  mem[widx(cpu_addr)] <= cpu_wdata;
    end
    assign io_rdata = rd_pipe[RD_LAT-1];

    // ---------------- ring model
    logic [63:0] exp_wr [$];   // {addr, data} of every port-B write still due
    logic [7:0]  m_fifo [$];   // codes stored in the ring, oldest first
    logic [7:0]  m_pend [$];   // accepted codes not yet stored
    int          m_tail;
    int          h_model;      // head value the CPU has published
`ifdef KBD_RING_DROP_EN
    int          m_ovf;
`endif

    function automatic void drain();
        logic [7:0] c;
        while (m_pend.size() > 0 && ((m_tail + 1) % DEPTH) != h_model) begin
            c = m_pend.pop_front();
            exp_wr.push_back({BASE + 32'(8 + 4 * m_tail), 24'd0, c});
            exp_wr.push_back({BASE, 32'((m_tail + 1) % DEPTH)});
            m_fifo.push_back(c);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endfunction

    function automatic void model_accept(input logic [7:0] c);
`ifdef KBD_RING_DROP_EN
        if (((m_tail + 1) % DEPTH) == h_model) begin
            if (m_ovf < 65535) m_ovf++;
        end else begin
            m_pend.push_back(c);
            drain();
        end
`else
        m_pend.push_back(c);
        drain();
`endif
    endfunction

    // Compare process: every port-B write must be the next one the model expects.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst) begin
            exp_wr.delete();
            m_fifo.delete();
            m_pend.delete();
            m_tail = 0;
`ifdef KBD_RING_DROP_EN
            m_ovf = 0;
`endif
            exp_wr.push_back({BASE, 32'd0});
            exp_wr.push_back({BASE + 32'd4, 32'd0});
        end else begin
            if (io_wren) begin
                if (exp_wr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %h data %h, want no write", io_addr, io_wdata);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", io_addr, e[63:32]);
                    check("wr_data", io_wdata, e[31:0]);
                end
            end
            if (kbd_valid && kbd_ready) model_accept(kbd_code);
        end
    end

    // ---------------- stimulus tasks
    task automatic set_head(input int h);
        h_model = h;
        drain();
        @(posedge clk); #1;
        cpu_addr  = BASE + 32'd4;
        cpu_wdata = 32'(h);
        cpu_we    = 1'b1;
        @(posedge clk); #1;
        cpu_we    = 1'b0;
    endtask

    // CPU pops n codes: data read from memory must match the model's order.
    task automatic consume(input int n);
        logic [7:0] c;
        for (int i = 0; i < n; i++) begin
            c = m_fifo.pop_front();
            check("ring_data", mem[widx(BASE + 32'(8 + 4 * h_model))], {24'd0, c});
            set_head((h_model + 1) % DEPTH);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!kbd_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(kbd_ready), 32'd1);
    endtask

    task automatic send_code(input logic [7:0] c, input int budget);
        int n;
        n = 0;
        @(posedge clk); #1;
        kbd_code  = c;
        kbd_valid = 1'b1;
        @(negedge clk);
        while (!kbd_ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("accept", 32'(kbd_ready), 32'd1);
        @(posedge clk); #1;
        kbd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        kbd_valid = 1'b0;
        cpu_we    = 1'b0;
        h_model   = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wren",  32'(io_wren),   32'd0);
        check("rst_addr",  io_addr,        BASE);
        check("rst_wdata", io_wdata,       32'd0);
        check("rst_ready", 32'(kbd_ready), 32'd0);
        check("rst_busy",  32'(busy),      32'd1);
`ifdef KBD_RING_DROP_EN
        check("rst_ovf",   32'(ovf_cnt),   32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("c0_wren", 32'(io_wren), 32'd0);
        @(negedge clk);
        check("c1_wren", 32'(io_wren), 32'd1);
        check("c1_addr", io_addr, 32'h0000_1000);
        check("c1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("c2_wren", 32'(io_wren), 32'd1);
        check("c2_addr", io_addr, 32'h0000_1004);
        check("c2_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("c3_busy",  32'(busy), 32'd0);
        check("c3_ready", 32'(kbd_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        lw  [1:8];
        logic [31:0] la  [1:8];
        logic [31:0] ld  [1:8];
        logic        lr  [1:8];
        int          bad;
        int          occ;
        bit [31:0]   snap [0:17];

        rst = 1'b1; kbd_valid = 1'b0; kbd_code = 8'd0;
        cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        h_model = 0;

        // ---- reset release and init writes
        do_reset();

        // ---- single code, latency pinned by hand
        @(posedge clk); #1;
        kbd_code = 8'h1C; kbd_valid = 1'b1;
        @(posedge clk); #1;
        kbd_valid = 1'b0;
        for (int k = 1; k <= RD_LAT + 4; k++) begin
            @(negedge clk);
            lw[k] = io_wren; la[k] = io_addr; ld[k] = io_wdata; lr[k] = kbd_ready;
        end
        check("lat_c1_ready",  32'(lr[1]), 32'd0);
        check("lat_data_wren", 32'(lw[RD_LAT+2]), 32'd1);
        check("lat_data_addr", la[RD_LAT+2], 32'h0000_1008);
        check("lat_data_val",  ld[RD_LAT+2], 32'h0000_001C);
        check("lat_tail_wren", 32'(lw[RD_LAT+3]), 32'd1);
        check("lat_tail_addr", la[RD_LAT+3], 32'h0000_1000);
        check("lat_tail_val",  ld[RD_LAT+3], 32'h0000_0001);
        check("lat_c4_ready",  32'(lr[RD_LAT+3]), 32'd0);
        check("lat_c5_ready",  32'(lr[RD_LAT+4]), 32'd1);
        check("mem_1008", mem[widx(32'h1008)], 32'h0000_001C);

        // ---- fill to capacity with head held at 0
        do_reset();
        for (int i = 0; i < 15; i++) begin
            send_code(8'h20 + 8'(i), 50);
            wait_idle(50);
        end
        check("full_tail_word", mem[widx(32'h1000)], 32'd15);
        check("full_last_data", mem[widx(32'h1040)], 32'h0000_002E);
`ifdef KBD_RING_DROP_EN
        for (int i = 0; i < 18; i++) snap[i] = mem[i];
        for (int i = 0; i < 3; i++) begin
            send_code(8'h70 + 8'(i), 50);
            wait_idle(50);
        end
        check("ovf_cnt", 32'(ovf_cnt), 32'd3);
        check("ovf_model", 32'(ovf_cnt), 32'(m_ovf));
        bad = 0;
        for (int i = 0; i < 18; i++) if (mem[i] != snap[i]) bad++;
        check("drop_mem_unchanged", 32'(bad), 32'd0);
        consume(15);
`else
        send_code(8'h77, 50);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (kbd_ready || io_wren || io_addr != 32'h0000_1004) bad++;
        end
        check("stall_window", 32'(bad), 32'd0);
        consume(1);
        wait_idle(50);
        check("wrap_data", mem[widx(32'h1044)], 32'h0000_0077);
        check("wrap_tail", mem[widx(32'h1000)], 32'd0);
        consume(15);
`endif

        // ---- random codes with a randomly lagging consumer
        for (int i = 0; i < 40; i++) begin
            occ = (m_tail - h_model + DEPTH) % DEPTH;
            if (occ == DEPTH - 1 || (occ > 0 && $urandom_range(0, 3) == 0))
                consume(int'($urandom_range(1, occ)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send_code(8'($urandom), 50);
            wait_idle(50);
            check("rand_tail_word", mem[widx(BASE)], 32'(m_tail));
        end
        consume(m_fifo.size());

        // ---- reset while the data word is being written
        do_reset();
        send_code(8'hA5, 50);
        bad = 1;
        for (int i = 0; i < 20 && bad != 0; i++) begin
            @(negedge clk);
            if (io_wren && io_addr != BASE) bad = 0;
        end
        check("reached_wr_data", 32'(bad), 32'd0);
        #1;
        do_reset();
        send_code(8'h5A, 50);
        wait_idle(50);
        check("post_rst_data", mem[widx(32'h1008)], 32'h0000_005A);
        check("post_rst_tail", mem[widx(32'h1000)], 32'd1);
        consume(1);

        repeat (4) @(negedge clk);
        check("writes_outstanding", 32'(exp_wr.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_kbd_ring_writer
